// File: rtl/rr_mux_scheduler_pkg.sv
// Shared encodings and sizing for the round-robin 8:1 mux scheduler.
package rr_mux_scheduler_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_mux_scheduler_pick.sv
// Rotate-by-ptr priority encoder: first set request at or after ptr, circularly.
module rr_pick8
  import rr_mux_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    pick = ptr + off;
    any  = |req;
  end

endmodule

// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler with bounded hold time driving a shared 8:1 data select.
//
//   state | meaning
//   IDLE  | no grant active, gnt=0, busy=0
//   GRANT | requester S owns the mux, hold_cnt counts its cycles
module rr_mux_scheduler
  import rr_mux_scheduler_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] I,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   S,
  output logic               busy,
  output logic               D
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, scan_ptr, pick, s_n;
  logic [CNT_W-1:0]   hold_cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               busy_n, any, rel;

  // A release re-scans from owner+1 in the same cycle, so the new grant has no idle bubble.
  rr_pick8 u_pick (
    .req  (req),
    .ptr  (scan_ptr),
    .pick (pick),
    .any  (any)
  );

  // Next-state, pointer, hold counter and registered-output values.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = hold_cnt;
    gnt_n    = gnt;
    s_n      = S;
    busy_n   = busy;
    rel      = 1'b0;
    scan_ptr = ptr;
    if (state == GRANT) rel = !req[S] || (hold_cnt == MAX_CNT);
    if (rel) scan_ptr = S + 3'd1;
    case (state)
      IDLE: begin
        if (any) begin
          state_n = GRANT;
          gnt_n   = NUM_REQ'(1) << pick;
          s_n     = pick;
          busy_n  = 1'b1;
          cnt_n   = CNT_W'(1);
        end else begin
          gnt_n  = '0;
          busy_n = 1'b0;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_n = hold_cnt + CNT_W'(1);
        end else begin
          ptr_n = scan_ptr;
          if (any) begin
            gnt_n  = NUM_REQ'(1) << pick;
            s_n    = pick;
            busy_n = 1'b1;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            busy_n  = 1'b0;
            cnt_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      S        <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= cnt_n;
      gnt      <= gnt_n;
      S        <= s_n;
      busy     <= busy_n;
    end
  end

  assign D = busy ? I[S] : 1'b0;

endmodule

// File: tb/tb_rr_mux_scheduler.sv
// Scoreboard bench for rr_mux_scheduler: behavioural model pushes expected outputs per cycle.
module tb_rr_mux_scheduler;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       d;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] I   = '0;
  logic [7:0] gnt;
  logic [2:0] S;
  logic       busy;
  logic       D;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // model state
  logic       m_busy  = 1'b0;
  logic [2:0] m_ptr   = '0;
  logic [2:0] m_owner = '0;
  int         m_cnt   = 0;

  rr_mux_scheduler #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .I    (I),
    .gnt  (gnt),
    .S    (S),
    .busy (busy),
    .D    (D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [2:0] scan(input logic [7:0] r, input logic [2:0] from);
    logic [2:0] idx;
    for (int k = 7; k >= 0; k--) begin
      idx = from + 3'(k);
      if (r[idx]) scan = idx;
    end
  endfunction

  task automatic model_step(input logic [7:0] r, input logic rs);
    if (rs) begin
      m_busy = 0; m_ptr = 0; m_owner = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (r != 0) begin
        m_owner = scan(r, m_ptr); m_busy = 1; m_cnt = 1;
      end
    end else if (r[m_owner] && m_cnt < MAX_HOLD) begin
      m_cnt++;
    end else begin
      m_ptr = m_owner + 3'd1;
      if (r != 0) begin
        m_owner = scan(r, m_ptr); m_cnt = 1;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r, input logic [7:0] data, input logic rs);
    exp_t e;
    @(negedge clk);
    rst = rs; req = r; I = data;
    model_step(r, rs);
    e.gnt  = m_busy ? (8'h01 << m_owner) : 8'h00;
    e.s    = m_owner;
    e.busy = m_busy;
    e.d    = m_busy ? data[m_owner] : 1'b0;
    e.cnt  = 4'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("S", S, e.s);
    chk("busy", busy, e.busy);
    chk("D", D, e.d);
    if (e.busy) chk("hold_cnt", dut.hold_cnt, e.cnt);
  endtask

  initial begin
    logic [7:0] data;

    // reset held with all requests high, then exactly one cycle to first grant
    cycle(8'hFF, 8'h00, 1'b1);
    chk("rst_gnt0", gnt, 8'h00);
    cycle(8'hFF, 8'h00, 1'b1);
    chk("rst_busy0", busy, 1'b0);
    chk("rst_S0", S, 3'd0);
    chk("rst_D0", D, 1'b0);
    cycle(8'hFF, 8'h00, 1'b0);
    chk("first_grant", gnt, 8'h01);

    // fairness: rotate 0..7,0 with four cycles each, no gap
    for (int k = 1; k < 36; k++) begin
      cycle(8'hFF, 8'hA5, 1'b0);
      chk("fair_order", gnt, 8'h01 << ((k / MAX_HOLD) % 8));
    end

    // early release with pointer wrap
    cycle(8'h00, 8'h00, 1'b1);
    cycle(8'h80, 8'h00, 1'b0);
    chk("wrap_own7", gnt, 8'h80);
    cycle(8'h81, 8'h00, 1'b0);
    cycle(8'h01, 8'h00, 1'b0);
    chk("wrap_to0", gnt, 8'h01);
    cycle(8'h81, 8'h00, 1'b0);
    chk("wrap_keep0", gnt, 8'h01);

    // sole continuous requester
    cycle(8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cycle(8'h08, 8'h00, 1'b0);
      chk("sole_gnt", gnt, 8'h08);
      chk("sole_cnt", dut.hold_cnt, (k % MAX_HOLD) + 1);
    end

    // data path on requester 5
    cycle(8'h00, 8'h00, 1'b1);
    cycle(8'h20, 8'b1011_1011, 1'b0);
    chk("data_d1", D, 1'b1);
    I[5] = 1'b0;
    #1;
    chk("data_d0_same_cycle", D, 1'b0);
    cycle(8'h00, 8'hFF, 1'b0);
    chk("data_idle_d0", D, 1'b0);

    // reset during third cycle of a grant, then restart from ptr 0
    cycle(8'h00, 8'h00, 1'b1);
    cycle(8'h08, 8'hFF, 1'b0);
    cycle(8'h08, 8'hFF, 1'b0);
    cycle(8'h08, 8'hFF, 1'b0);
    cycle(8'h08, 8'hFF, 1'b1);
    chk("midrst_gnt", gnt, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    cycle(8'hFF, 8'hFF, 1'b0);
    chk("midrst_restart", gnt, 8'h01);

    // random traffic against the model
    for (int k = 0; k < 200; k++) begin
      data = 8'($urandom);
      cycle(8'($urandom) & 8'($urandom), data, ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
